// File: rtl/brcomp_arbiter.sv
// -----------------------------------------------------------------------------
// brcomp_arbiter
//
// Shares one combinational branch comparator between two requesters. A request
// is accepted in IDLE and its operands are registered. The comparator is driven
// from those registers during CMP, and the decoded branch outcome is registered
// at the end of CMP. The outcome is then held on the owning port's response
// channel in RESP until that requester consumes it.
//
// Parameters
//   FAIR_RR        1 = round-robin on ties, 0 = fixed priority (port 0 wins)
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o  request handshake (N = 0, 1)
//   reqN_rs1_i, reqN_rs2_i       operands
//   reqN_funct3_i                RV32I branch funct3
//   rspN_valid_o / rspN_ready_i  response handshake
//   rspN_taken_o                 branch condition true
//   rspN_illegal_o               funct3 was 010 or 011
//   cmp_rs1_o, cmp_rs2_o         operands to the shared comparator
//   cmp_unsign_o                 1 = unsigned compare
//   cmp_less_i, cmp_equal_i      comparator results
//   busy_o                       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module brcomp_arbiter #(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_rs1_i,
  input  logic [31:0] req0_rs2_i,
  input  logic [2:0]  req0_funct3_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_rs1_i,
  input  logic [31:0] req1_rs2_i,
  input  logic [2:0]  req1_funct3_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic        rsp0_taken_o,
  output logic        rsp0_illegal_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic        rsp1_taken_o,
  output logic        rsp1_illegal_o,
  output logic [31:0] cmp_rs1_o,
  output logic [31:0] cmp_rs2_o,
  output logic        cmp_unsign_o,
  input  logic        cmp_less_i,
  input  logic        cmp_equal_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        port_q, port_d;
  logic        last_grant_q, last_grant_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic        busy_q, busy_d;

  logic        grant_valid;
  logic        grant_port;
  logic        handshake;
  logic        rsp_consumed;
  logic        dec_taken;
  logic        dec_illegal;

  // Grant selection. On a tie with round-robin enabled, the port that did not
  // win last time is chosen; last_grant resets to 1 so port 0 wins the first tie.
  always_comb begin
    grant_valid = req0_valid_i | req1_valid_i;
    grant_port  = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant_port = FAIR_RR ? ~last_grant_q : 1'b0;
    end else if (req1_valid_i) begin
      grant_port = 1'b1;
    end
  end

  // Acceptance is only possible in IDLE and never while reset is asserted.
  assign handshake    = (state_q == S_IDLE) && !rst_i && grant_valid;
  assign req0_ready_o = (state_q == S_IDLE) && !rst_i && req0_valid_i && !grant_port;
  assign req1_ready_o = (state_q == S_IDLE) && !rst_i && req1_valid_i &&  grant_port;

  assign rsp_consumed = port_q ? rsp1_ready_i : rsp0_ready_i;

  // funct3 decode of the comparator result. 010/011 are not branch encodings.
  always_comb begin
    dec_taken   = 1'b0;
    dec_illegal = 1'b0;
    unique case (funct3_q)
      3'b000:          dec_taken = cmp_equal_i;
      3'b001:          dec_taken = ~cmp_equal_i;
      3'b100, 3'b110:  dec_taken = cmp_less_i;
      3'b101, 3'b111:  dec_taken = ~cmp_less_i;
      default:         dec_illegal = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    funct3_d     = funct3_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    taken_d      = taken_q;
    illegal_d    = illegal_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          rs1_d        = grant_port ? req1_rs1_i    : req0_rs1_i;
          rs2_d        = grant_port ? req1_rs2_i    : req0_rs2_i;
          funct3_d     = grant_port ? req1_funct3_i : req0_funct3_i;
          port_d       = grant_port;
          last_grant_d = grant_port;
          state_d      = S_CMP;
        end
      end
      S_CMP: begin
        taken_d      = dec_taken;
        illegal_d    = dec_illegal;
        rsp0_valid_d = ~port_q;
        rsp1_valid_d =  port_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        // taken/illegal are left untouched so they stay stable while stalled.
        if (rsp_consumed) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy is registered, so it follows the state being entered.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rs1_q        <= 32'd0;
      rs2_q        <= 32'd0;
      funct3_q     <= 3'd0;
      port_q       <= 1'b0;
      last_grant_q <= 1'b1;
      taken_q      <= 1'b0;
      illegal_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      funct3_q     <= funct3_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      taken_q      <= taken_d;
      illegal_q    <= illegal_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
    end
  end

  // The comparator always sees the captured operands, so its inputs hold the
  // last request's values outside CMP.
  assign cmp_rs1_o    = rs1_q;
  assign cmp_rs2_o    = rs2_q;
  assign cmp_unsign_o = funct3_q[1];

  // Only the owning port sees taken/illegal; the other port reads zero.
  assign rsp0_valid_o   = rsp0_valid_q;
  assign rsp1_valid_o   = rsp1_valid_q;
  assign rsp0_taken_o   = taken_q   & ~port_q;
  assign rsp1_taken_o   = taken_q   &  port_q;
  assign rsp0_illegal_o = illegal_q & ~port_q;
  assign rsp1_illegal_o = illegal_q &  port_q;
  assign busy_o         = busy_q;

endmodule
